// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: a PAT_LEN-bit pattern is sent MSB-first, repeated N times with G idle bits between instances.
// All outputs are registered and are computed from the next state, so the first bit appears the cycle after start.
module seq_pattern_gen #(
    parameter int             PAT_LEN     = 6,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 6'b111010,
    parameter int             CNT_W       = 8,
    parameter int             GAP_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               start,
    input  logic [CNT_W-1:0]   repeat_cnt,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    output logic               out,
    output logic               out_valid,
    output logic               last_bit,
    output logic               busy,
    output logic               done
);

    localparam int IW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               out_d, out_valid_d, last_bit_d, busy_d, done_d;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gcnt_d  = gcnt_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE: begin
                if (pat_load) begin
                    pat_d = pat_in;
                end
                if (start) begin
                    rem_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    gap_d   = gap;
                    idx_d   = IDX_MAX;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // idx_q is the bit currently on out; idx 0 closes an instance
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IW'(1);
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else if (gap_q == '0) begin
                        idx_d = IDX_MAX;
                    end else begin
                        gcnt_d  = gap_q;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gcnt_q <= GAP_W'(1)) begin
                    idx_d   = IDX_MAX;
                    state_d = S_SEND;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d == S_SEND);
        out_d       = out_valid_d & pat_d[idx_d];
        last_bit_d  = out_valid_d && (idx_d == '0);
        busy_d      = (state_d == S_SEND) || (state_d == S_GAP);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= PAT_DEFAULT;
            idx_q     <= '0;
            rem_q     <= '0;
            gcnt_q    <= '0;
            gap_q     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            gcnt_q    <= gcnt_d;
            gap_q     <= gap_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            last_bit  <= last_bit_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
